// File: rtl/dma_engine.sv
// DMA initiator: announces reserved pipeline slots and moves words between
// data/instruction memory and the I/O-device stream port.
module dma_engine #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned GAP       = 1,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic              imem_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              dma_dm_to_id,
  output logic              dma_id_to_dm,
  output logic              dma_imem_select,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              io_rx_valid,
  output logic              io_rx_ready,
  input  logic [31:0]       io_rx_data,
  output logic              io_tx_valid,
  input  logic              io_tx_ready,
  output logic [31:0]       io_tx_data
);

  localparam int unsigned PTR_W = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_dir;
  logic              r_imem;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [GAP_W-1:0]  r_gap;
  logic              r_p1_vld;
  logic              r_p1_we;
  logic [ADDR_W-1:0] r_p1_addr;
  logic [31:0]       r_p1_data;
  logic              r_p2_vld;
  logic              r_p2_we;
  logic [ADDR_W-1:0] r_p2_addr;
  logic [31:0]       r_p2_data;
  logic              r_rd_wait;
  logic              r_rd_vld;
  logic [31:0]       r_rd_data;
  logic [31:0]       r_q [TXQ_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_infl;

  logic              w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic              w_accept;

  // Reads already committed to the queue count against its free space.
  assign w_credit  = (SUM_W'(r_cnt) + SUM_W'(r_infl)) < SUM_W'(TXQ_DEPTH);
  assign w_issue   = (r_state == S_RUN) && (r_gap == '0) &&
                     (r_dir ? io_rx_valid : w_credit);
  assign w_push    = r_rd_vld;
  assign w_pop     = (r_cnt != '0) && io_tx_ready;
  assign w_drained = !r_p1_vld && !r_p2_vld &&
                     (r_dir || ((r_infl == '0) && (r_cnt == '0)));
  assign w_accept  = start && (r_state == S_IDLE);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && (r_rem == LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Command latch, address/length counters and announcement gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= 1'b0;
      r_imem <= 1'b0;
      r_addr <= '0;
      r_rem  <= '0;
      r_gap  <= '0;
    end else begin
      if (w_accept) begin
        r_dir  <= dir;
        r_imem <= imem_sel;
        r_addr <= base_addr;
        r_rem  <= len;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - LEN_W'(1);
      end
      if (w_issue) r_gap <= GAP_W'(GAP);
      else if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
    end
  end

  // Two-stage announce-to-access delay pipe plus read-return flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld  <= 1'b0;
      r_p1_we   <= 1'b0;
      r_p1_addr <= '0;
      r_p1_data <= '0;
      r_p2_vld  <= 1'b0;
      r_p2_we   <= 1'b0;
      r_p2_addr <= '0;
      r_p2_data <= '0;
      r_rd_wait <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_p1_vld <= w_issue;
      if (w_issue) begin
        r_p1_we   <= r_dir;
        r_p1_addr <= r_addr;
        r_p1_data <= r_dir ? io_rx_data : 32'h0;
      end
      r_p2_vld  <= r_p1_vld;
      r_p2_we   <= r_p1_we;
      r_p2_addr <= r_p1_addr;
      r_p2_data <= r_p1_data;
      r_rd_wait <= r_p2_vld && !r_p2_we;
      r_rd_vld  <= r_rd_wait;
      if (r_rd_wait) r_rd_data <= mem_rdata;
    end
  end

  // TX queue and in-flight read accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TXQ_DEPTH; i++) r_q[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_infl <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= r_rd_data;
        r_wptr      <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      case ({w_issue && !r_dir, w_push})
        2'b10:   r_infl <= r_infl + CNT_W'(1);
        2'b01:   r_infl <= r_infl - CNT_W'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign dma_dm_to_id    = w_issue && !r_dir;
  assign dma_id_to_dm    = w_issue && r_dir;
  assign dma_imem_select = w_issue && r_imem;
  assign io_rx_ready     = w_issue && r_dir;
  assign mem_en          = r_p2_vld;
  assign mem_we          = r_p2_vld && r_p2_we;
  assign mem_addr        = r_p2_addr;
  assign mem_wdata       = r_p2_data;
  assign io_tx_valid     = (r_cnt != '0);
  assign io_tx_data      = r_q[r_rptr];

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with a behavioural memory and I/O model.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        imem_sel = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] len = '0;
  logic        busy, done;
  logic        dma_dm_to_id, dma_id_to_dm, dma_imem_select;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        io_rx_valid, io_rx_ready;
  logic [31:0] io_rx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic [31:0] io_tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  // I/O receive source
  logic [31:0] rx_words [16];
  int          rx_cnt = 0;
  int          rx_idx = 0;
  logic        rx_en  = 1'b0;

  // Event logs
  int          ann_cyc  [$];
  logic        ann_imem [$];
  logic        ann_rd   [$];
  int          mem_cyc  [$];
  logic [11:0] mem_a_l  [$];
  logic        mem_we_l [$];
  logic [31:0] mem_wd_l [$];
  logic [31:0] tx_l     [$];
  int          done_cyc [$];
  logic        done_bsy [$];
  int          both_err = 0;
  int          rdy_err  = 0;
  int a0, m0, t0, d0;

  dma_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .imem_sel(imem_sel),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .dma_dm_to_id(dma_dm_to_id), .dma_id_to_dm(dma_id_to_dm),
    .dma_imem_select(dma_imem_select), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_rx_valid(io_rx_valid), .io_rx_ready(io_rx_ready), .io_rx_data(io_rx_data),
    .io_tx_valid(io_tx_valid), .io_tx_ready(io_tx_ready), .io_tx_data(io_tx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: word at address a reads as 0x90 + a, data valid the cycle after mem_en.
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= 32'h90 + 32'(mem_addr);

  assign io_rx_valid = rx_en && (rx_idx < rx_cnt);
  assign io_rx_data  = rx_words[rx_idx[3:0]];
  always @(posedge clk) if (io_rx_valid && io_rx_ready) rx_idx <= rx_idx + 1;

  // Monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (dma_dm_to_id || dma_id_to_dm) begin
      ann_cyc.push_back(cyc);
      ann_imem.push_back(dma_imem_select);
      ann_rd.push_back(dma_dm_to_id);
    end
    if (dma_dm_to_id && dma_id_to_dm) both_err = both_err + 1;
    if (io_rx_ready && !dma_id_to_dm) rdy_err = rdy_err + 1;
    if (mem_en) begin
      mem_cyc.push_back(cyc);
      mem_a_l.push_back(mem_addr);
      mem_we_l.push_back(mem_we);
      mem_wd_l.push_back(mem_wdata);
    end
    if (io_tx_valid && io_tx_ready) tx_l.push_back(io_tx_data);
    if (done) begin
      done_cyc.push_back(cyc);
      done_bsy.push_back(busy);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    a0 = ann_cyc.size();
    m0 = mem_cyc.size();
    t0 = tx_l.size();
    d0 = done_cyc.size();
  endtask

  task automatic do_start(input logic d, input logic im, input logic [11:0] ba, input logic [11:0] ln);
    @(posedge clk); #1;
    dir = d; imem_sel = im; base_addr = ba; len = ln; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_cyc.size() > d0) break;
    end
    if (k >= budget) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks a read transfer of n words from base, announced every other cycle.
  task automatic check_read(input string tag, input logic [11:0] base, input int n);
    check_eq({tag, "_ann_n"}, 32'(ann_cyc.size() - a0), 32'(n));
    check_eq({tag, "_mem_n"}, 32'(mem_cyc.size() - m0), 32'(n));
    check_eq({tag, "_tx_n"},  32'(tx_l.size() - t0), 32'(n));
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_ann_rd"},   32'(ann_rd[a0+k]), 32'd1);
      check_eq({tag, "_ann_imem"}, 32'(ann_imem[a0+k]), 32'd0);
      check_eq({tag, "_mem_lat"},  32'(mem_cyc[m0+k] - ann_cyc[a0+k]), 32'd2);
      check_eq({tag, "_mem_addr"}, 32'(mem_a_l[m0+k]), 32'(base + 12'(k)));
      check_eq({tag, "_mem_we"},   32'(mem_we_l[m0+k]), 32'd0);
      check_eq({tag, "_tx_data"},  tx_l[t0+k], 32'h90 + 32'(base) + 32'(k));
    end
  endtask

  initial begin
    int bad;
    logic [8:0] ctl;

    // Reset state
    wait_cycles(3);
    ctl = {busy, done, dma_dm_to_id, dma_id_to_dm, dma_imem_select,
           mem_en, mem_we, io_rx_ready, io_tx_valid};
    check_eq("rst_ctl", 32'(ctl), 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Test 1: mem->I/O, dmem, base 0x010, len 3
    io_tx_ready = 1'b1;
    snap();
    do_start(1'b0, 1'b0, 12'h010, 12'd3);
    wait_done("t1", 100);
    check_read("t1", 12'h010, 3);
    check_eq("t1_first_ann", 32'(ann_cyc[a0] - start_cyc), 32'd1);
    check_eq("t1_ann_gap1", 32'(ann_cyc[a0+1] - ann_cyc[a0]), 32'd2);
    check_eq("t1_ann_gap2", 32'(ann_cyc[a0+2] - ann_cyc[a0]), 32'd4);
    check_eq("t1_done_n", 32'(done_cyc.size() - d0), 32'd1);
    check_eq("t1_done_busy", 32'(done_bsy[d0]), 32'd0);

    // Test 2: I/O->mem, imem, address wrap
    rx_words[0] = 32'h11; rx_words[1] = 32'h22; rx_words[2] = 32'h33;
    rx_cnt = 3;
    rx_en  = 1'b1;
    snap();
    do_start(1'b1, 1'b1, 12'hFFE, 12'd3);
    wait_done("t2", 100);
    check_eq("t2_ann_n", 32'(ann_cyc.size() - a0), 32'd3);
    check_eq("t2_mem_n", 32'(mem_cyc.size() - m0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq("t2_ann_wr",   32'(ann_rd[a0+k]), 32'd0);
      check_eq("t2_ann_imem", 32'(ann_imem[a0+k]), 32'd1);
      check_eq("t2_mem_lat",  32'(mem_cyc[m0+k] - ann_cyc[a0+k]), 32'd2);
      check_eq("t2_mem_we",   32'(mem_we_l[m0+k]), 32'd1);
      check_eq("t2_wdata",    mem_wd_l[m0+k], rx_words[k]);
    end
    check_eq("t2_addr0", 32'(mem_a_l[m0]),   32'hFFE);
    check_eq("t2_addr1", 32'(mem_a_l[m0+1]), 32'hFFF);
    check_eq("t2_addr2", 32'(mem_a_l[m0+2]), 32'h000);
    check_eq("t2_done_n", 32'(done_cyc.size() - d0), 32'd1);

    // Test 3: TX back-pressure limits issue to queue depth
    io_tx_ready = 1'b0;
    snap();
    do_start(1'b0, 1'b0, 12'h100, 12'd8);
    wait_cycles(30);
    check_eq("t3_stall_ann", 32'(ann_cyc.size() - a0), 32'd4);
    check_eq("t3_stall_busy", 32'(busy), 32'd1);
    io_tx_ready = 1'b1;
    wait_done("t3", 200);
    check_read("t3", 12'h100, 8);
    check_eq("t3_done_n", 32'(done_cyc.size() - d0), 32'd1);

    // Test 4: RX starvation
    rx_en = 1'b0;
    rx_words[3] = 32'hCAFE0001; rx_words[4] = 32'hCAFE0002;
    rx_cnt = 5;
    snap();
    do_start(1'b1, 1'b0, 12'h040, 12'd2);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) bad++;
    end
    check_eq("t4_busy_hold", 32'(bad), 32'd0);
    check_eq("t4_no_ann", 32'(ann_cyc.size() - a0), 32'd0);
    rx_en = 1'b1;
    wait_done("t4", 100);
    check_eq("t4_mem_n", 32'(mem_cyc.size() - m0), 32'd2);
    check_eq("t4_addr0", 32'(mem_a_l[m0]), 32'h040);
    check_eq("t4_wd0", mem_wd_l[m0], 32'hCAFE0001);
    check_eq("t4_addr1", 32'(mem_a_l[m0+1]), 32'h041);
    check_eq("t4_wd1", mem_wd_l[m0+1], 32'hCAFE0002);
    check_eq("t4_done_n", 32'(done_cyc.size() - d0), 32'd1);

    // Test 5a: zero length
    snap();
    do_start(1'b0, 1'b0, 12'h300, 12'd0);
    wait_done("t5a", 20);
    check_eq("t5a_done_lat", 32'(done_cyc[d0] - start_cyc), 32'd1);
    wait_cycles(5);
    check_eq("t5a_no_ann", 32'(ann_cyc.size() - a0), 32'd0);
    check_eq("t5a_no_mem", 32'(mem_cyc.size() - m0), 32'd0);

    // Test 5b: start while busy is ignored
    snap();
    do_start(1'b0, 1'b0, 12'h010, 12'd3);
    wait_cycles(1);
    do_start(1'b1, 1'b1, 12'h200, 12'd5);
    wait_done("t5b", 100);
    wait_cycles(10);
    check_read("t5b", 12'h010, 3);
    check_eq("t5b_done_n", 32'(done_cyc.size() - d0), 32'd1);

    // Test 6: reset mid-transfer
    snap();
    do_start(1'b0, 1'b0, 12'h020, 12'd6);
    bad = 0;
    while (ann_cyc.size() - a0 < 2 && bad < 50) begin
      @(posedge clk); #1;
      bad++;
    end
    check_eq("t6_two_ann", 32'(ann_cyc.size() - a0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    ctl = {busy, done, dma_dm_to_id, dma_id_to_dm, dma_imem_select,
           mem_en, mem_we, io_rx_ready, io_tx_valid};
    check_eq("t6_rst_ctl", 32'(ctl), 32'd0);
    check_eq("t6_rst_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_rst_wdata", mem_wdata, 32'd0);
    check_eq("t6_rst_txdata", io_tx_data, 32'd0);
    snap();
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(12);
    check_eq("t6_no_mem", 32'(mem_cyc.size() - m0), 32'd0);
    check_eq("t6_no_done", 32'(done_cyc.size() - d0), 32'd0);
    snap();
    do_start(1'b0, 1'b0, 12'h010, 12'd2);
    wait_done("t6", 100);
    check_read("t6", 12'h010, 2);
    check_eq("t6_done_n", 32'(done_cyc.size() - d0), 32'd1);

    // Global protocol checks
    check_eq("both_ann", 32'(both_err), 32'd0);
    check_eq("rx_ready_outside_issue", 32'(rdy_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
- DMA initiator for the 5-stage core. It produces the dma_dm_to_id, dma_id_to_dm and dma_imem_select slot announcements that the pipeline control consumes.
- It moves 32-bit words between data or instruction memory and an I/O-device (ID) stream port.
- Memory accesses land in the pipeline's reserved slot, two cycles after each announcement.
- Configured by a start/len/addr command from the host; reports busy/done.

Parameters:
- ADDR_W, 12, memory word-address width.
- LEN_W, 12, transfer length width, in words.
- GAP, 1, minimum idle cycles between consecutive announcements (0 = back-to-back).
- TXQ_DEPTH, 4, mem-to-I/O output queue depth (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; ignored while busy
- dir  in  1  0 = memory to I/O (dm_to_id), 1 = I/O to memory (id_to_dm); sampled at start
- imem_sel  in  1  1 = target instruction memory, 0 = data memory; sampled at start
- base_addr  in  ADDR_W  first word address; sampled at start
- len  in  LEN_W  word count; sampled at start
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- dma_dm_to_id  out  1  announce: memory-read slot
- dma_id_to_dm  out  1  announce: memory-write slot
- dma_imem_select  out  1  announce target; 1 = imem
- mem_en  out  1  memory access strobe (announce + 2)
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0
- io_rx_valid  in  1  I/O-to-memory word available
- io_rx_ready  out  1  word accepted this cycle
- io_rx_data  in  32  incoming word
- io_tx_valid  out  1  memory-to-I/O word available
- io_tx_ready  in  1  consumer accepts
- io_tx_data  out  32  outgoing word

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; counters, queue and delay pipe are cleared. Reset mid-transfer aborts it: no further mem_en and no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with len != 0. Latch dir, imem_sel, addr = base_addr, remaining = len.
  - IDLE -> DONE on start with len = 0. No announcement or memory access occurs.
  - RUN -> DRAIN in the cycle the last announcement issues.
  - DRAIN -> DONE when the delay pipe is empty and, for dir = 0, the read-return flop and TX queue are also empty.
  - DONE -> IDLE after one cycle. done = 1 only in DONE.
  - busy = 1 in RUN and DRAIN.
- Issue condition (RUN only): the gap counter has expired, and:
  - dir = 1: io_rx_valid is high.
  - dir = 0: TX credit > 0, where credit = TXQ_DEPTH − occupancy − reads in flight.
- On issue:
  - Exactly one of dma_dm_to_id / dma_id_to_dm is high for one cycle; dma_imem_select = latched imem_sel in the same cycle.
  - For dir = 1, io_rx_ready = 1 in that cycle (combinational from the issue condition), and io_rx_data is captured.
  - addr and we/data enter a 2-stage delay pipe; addr increments modulo 2^ADDR_W (wraps); remaining decrements; the gap counter reloads with GAP.
- Announcement outputs are 0 whenever no issue occurs. io_rx_ready is never high outside an issue cycle.
- Memory access: mem_en/mem_we/mem_addr/mem_wdata come from pipe stage 2, exactly 2 cycles after the announce.
- Read return: read data is registered one cycle after mem_en and pushed into the TX queue. Total announce-to-queue latency is 4 cycles.
- TX queue:
  - Standard FIFO; io_tx_valid = not empty.
  - Pop when io_tx_valid and io_tx_ready are both high.
  - Simultaneous push and pop on a full queue is legal: occupancy is unchanged.
  - The credit rule guarantees no overflow.
- start while busy or in DONE: ignored. Latched configuration is unchanged.
- With GAP = 1, announcements are at most every other cycle. This leaves the pipeline a free load/store slot.

Test Plan:
- dir=0, imem_sel=0, base_addr=0x010, len=3, io_tx_ready=1, memory word k holds 0xA0+k.
  - dma_dm_to_id pulses at T, T+2, T+4 with dma_imem_select = 0.
  - mem_en with addresses 0x010, 0x011, 0x012 at T+2, T+4, T+6.
  - io_tx_data sequence 0xA0, 0xA1, 0xA2.
  - done pulses once; busy falls in the same cycle.
- dir=1, imem_sel=1, base_addr=0xFFE, len=3, rx words 0x11, 0x22, 0x33.
  - dma_id_to_dm pulses with dma_imem_select = 1.
  - Writes land at 0xFFE, 0xFFF, 0x000 (address wrap), each 2 cycles after its announce.
- dir=0, len=8, io_tx_ready held 0.
  - Exactly 4 announcements issue, then issue stalls with busy = 1.
  - Raising io_tx_ready resumes issue; all 8 words are delivered in order, with no overflow.
- dir=1, len=2, io_rx_valid = 0 for 10 cycles.
  - No announcements; busy = 1 throughout.
  - Once valid rises, both words are written and done follows.
- len=0 start: done pulses in the next cycle; no announcement and no mem_en. A start pulse during busy is ignored (transfer count and addresses unchanged).
- Assert rst_n low mid-transfer (dir=0, len=6, after 2 announcements).
  - All outputs go to 0 immediately; no subsequent mem_en or done.
  - A new start after reset behaves normally.
